ring_decoder: RTL and testbench
===============================

Name: ring_decoder

Overview:
- Receive end of the one-hot ring-counter bus: samples a WIDTH-bit one-hot phase word each valid cycle.
- Converts the word to a binary phase index and checks each step is a legal single-position left rotation.
- Counts completed revolutions and flags malformed words and skipped phases.
- Sits downstream of the ring counter; feeds phase-sequenced control logic and the lab debug display.

Parameters:
- WIDTH, 4, number of ring positions (one-hot width), >= 2
- IDXW, 2, index width, = clog2(WIDTH), set by integrator
- CNTW, 8, revolution counter width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset (0 = reset asserted)
- ring_in  input  WIDTH  one-hot phase word from ring counter
- in_valid  input  1  ring_in is sampled this cycle when 1
- index  output  IDXW  binary position of the set bit of the last accepted word
- index_valid  output  1  decoder is locked and index is meaningful
- step_err  output  1  one-cycle pulse: one-hot word but not hold/advance
- onehot_err  output  1  one-cycle pulse: word with zero or >1 bits set
- rev_count  output  CNTW  completed revolutions, wraps modulo 2^CNTW

Behaviour:
- Reset (reset=0, asynchronous): state=SEARCH, index=0, index_valid=0, step_err=0, onehot_err=0, rev_count=0; takes effect immediately, mid-operation included.
- All outputs registered; response to a sample at edge N is visible after edge N (1-cycle latency).
- in_valid=0: no state change; step_err/onehot_err drive 0 that cycle; index, index_valid, rev_count hold.
- Legal word: exactly one bit set; decoded index k = position of that bit (bit 0 -> 0).
- States SEARCH and LOCKED, evaluated only on in_valid=1.
- SEARCH, legal word k: index<=k, index_valid<=1, go LOCKED; no errors, no count.
- SEARCH, illegal word: onehot_err<=1, stay SEARCH, index_valid stays 0.
- LOCKED, prior index p, legal word k:
  - k==p (hold): legal; no change, no pulse.
  - k==(p+1) mod WIDTH (advance): index<=k; if p==WIDTH-1 and k==0, rev_count<=rev_count+1, wrapping all-ones -> 0.
  - any other k (skip/reverse): step_err<=1, index<=k (resync), stay LOCKED, no count.
- LOCKED, illegal word (0 or multi-hot): onehot_err<=1, index_valid<=0, go SEARCH; index holds its last value; rev_count holds.
- step_err and onehot_err are never asserted together.
- rev_count is cleared only by reset; relocking after SEARCH does not clear it.

Optional Feature:
- Macro RING_DECODER_ERRCNT_EN.
- Defined: adds output err_count (8 bits), reset 0; increments by 1 on each cycle where step_err or onehot_err is asserted; saturates at 255 (no wrap).
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then lock: reset=0 for 3 cycles, release, in_valid=1, ring_in=0001 -> after next edge index=0, index_valid=1, no error pulses.
- Full rotation: from locked at 0001, drive 0010,0100,1000,0001 -> index 1,2,3,0; rev_count 0->1 on the 1000->0001 step; repeat 256 revolutions -> rev_count wraps to 0.
- Hold and gaps: locked at 0100, drive 0100 twice then in_valid=0 for 2 cycles -> index stays 2, no pulses, rev_count unchanged.
- Skip: locked at 0001, drive 0100 -> step_err single-cycle pulse, index=2, index_valid stays 1; then 1000 -> index=3, no error.
- Malformed: locked at 0010, drive 0110 -> onehot_err pulse, index_valid=0, index holds 1; drive 0000 -> onehot_err again; drive 1000 -> index_valid=1, index=3, no step_err.
- Async reset mid-run: locked with rev_count=5, assert reset between clock edges -> all outputs 0 immediately, before the next edge; with RING_DECODER_ERRCNT_EN defined, also drive 300 errors -> err_count=255.

Source files
------------

// File: rtl/ring_decoder.sv
// ring_decoder: receive end of the one-hot ring-counter bus.
// Decodes each accepted one-hot phase word to a binary index, checks that
// successive words hold or advance by exactly one position, counts completed
// revolutions and flags malformed words and skipped phases.
// Optional build macro: RING_DECODER_ERRCNT_EN adds a saturating 8-bit
// err_count output that tallies every error pulse.
module ring_decoder #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 2,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             in_valid,
  output logic [IDXW-1:0]  index,
  output logic             index_valid,
  output logic             step_err,
  output logic             onehot_err,
  output logic [CNTW-1:0]  rev_count
`ifdef RING_DECODER_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  // True when exactly one bit of the word is set.
  function automatic logic is_onehot(input logic [WIDTH-1:0] w);
    return (w != '0) && ((w & (w - 1'b1)) == '0);
  endfunction

  // Binary position of the set bit; only meaningful for a one-hot word.
  function automatic logic [IDXW-1:0] encode(input logic [WIDTH-1:0] w);
    logic [IDXW-1:0] k;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w[i]) k = k | IDXW'(i);
    end
    return k;
  endfunction

  // Position that follows p in the ring.
  function automatic logic [IDXW-1:0] next_pos(input logic [IDXW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  state_t          state_q, state_d;
  logic            word_legal;
  logic [IDXW-1:0] word_idx;
  logic [IDXW-1:0] index_d;
  logic            index_valid_d;
  logic            step_err_d;
  logic            onehot_err_d;
  logic [CNTW-1:0] rev_count_d;

  assign word_legal = is_onehot(ring_in);
  assign word_idx   = encode(ring_in);

  // Next-state and next-output decision for the current sample.
  always_comb begin
    state_d       = state_q;
    index_d       = index;
    index_valid_d = index_valid;
    step_err_d    = 1'b0;
    onehot_err_d  = 1'b0;
    rev_count_d   = rev_count;
    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          if (word_legal) begin
            index_d       = word_idx;
            index_valid_d = 1'b1;
            state_d       = LOCKED;
          end else begin
            onehot_err_d  = 1'b1;
          end
        end
        LOCKED: begin
          if (!word_legal) begin
            onehot_err_d  = 1'b1;
            index_valid_d = 1'b0;
            state_d       = SEARCH;
          end else if (word_idx == index) begin
            index_d = index;
          end else if (word_idx == next_pos(index)) begin
            index_d = word_idx;
            // advancing out of the last position closes a revolution
            if (index == LAST_IDX) rev_count_d = rev_count + 1'b1;
          end else begin
            // skip or reverse: flag it and resynchronise to the new phase
            step_err_d = 1'b1;
            index_d    = word_idx;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      index       <= '0;
      index_valid <= 1'b0;
      step_err    <= 1'b0;
      onehot_err  <= 1'b0;
      rev_count   <= '0;
    end else begin
      state_q     <= state_d;
      index       <= index_d;
      index_valid <= index_valid_d;
      step_err    <= step_err_d;
      onehot_err  <= onehot_err_d;
      rev_count   <= rev_count_d;
    end
  end

`ifdef RING_DECODER_ERRCNT_EN
  // Saturating tally of error pulses, advanced in step with the pulse register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if ((step_err_d || onehot_err_d) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// Testbench for ring_decoder (default WIDTH=4, IDXW=2, CNTW=8).
// Define RING_DECODER_ERRCNT_EN at compile time to also exercise err_count.
module tb_ring_decoder;

  logic       clk;
  logic       reset;
  logic [3:0] ring_in;
  logic       in_valid;
  logic [1:0] index;
  logic       index_valid;
  logic       step_err;
  logic       onehot_err;
  logic [7:0] rev_count;
`ifdef RING_DECODER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  ring_decoder #(.WIDTH(4), .IDXW(2), .CNTW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .ring_in     (ring_in),
    .in_valid    (in_valid),
    .index       (index),
    .index_valid (index_valid),
    .step_err    (step_err),
    .onehot_err  (onehot_err),
    .rev_count   (rev_count)
`ifdef RING_DECODER_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] r;
    logic [1:0] idx;
    logic       iv;
    logic       se;
    logic       oe;
    logic [7:0] rev;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t exp_q[$];
  vec_t tbl[25];

  function automatic vec_t mk(input logic v, input logic [3:0] r, input logic [1:0] idx,
                              input logic iv, input logic se, input logic oe, input logic [7:0] rev);
    vec_t t;
    t.v = v; t.r = r; t.idx = idx; t.iv = iv; t.se = se; t.oe = oe; t.rev = rev;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pop the oldest expectation and compare against the DUT outputs.
  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("index", 32'(index), 32'(e.idx));
    chk("index_valid", 32'(index_valid), 32'(e.iv));
    chk("step_err", 32'(step_err), 32'(e.se));
    chk("onehot_err", 32'(onehot_err), 32'(e.oe));
    chk("rev_count", 32'(rev_count), 32'(e.rev));
  endtask

  // Drive one sample, record its expected response, sample after the edge.
  task automatic apply(input vec_t t);
    @(negedge clk);
    in_valid = t.v;
    ring_in  = t.r;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Reference model state for the long rotation sequence.
  logic [1:0] m_idx;
  logic [7:0] m_rev;

  task automatic rotate(input int revs);
    logic [1:0] n;
    for (int r = 0; r < revs; r++) begin
      for (int j = 0; j < 4; j++) begin
        n = m_idx + 2'd1;
        if (m_idx == 2'd3) m_rev = m_rev + 8'd1;
        m_idx = n;
        apply(mk(1'b1, 4'b0001 << n, n, 1'b1, 1'b0, 1'b0, m_rev));
      end
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 4'b0011, 2'd0, 0, 0, 1, 8'd0); // illegal while searching
    tbl[1]  = mk(1, 4'b0001, 2'd0, 1, 0, 0, 8'd0); // lock
    tbl[2]  = mk(1, 4'b0010, 2'd1, 1, 0, 0, 8'd0);
    tbl[3]  = mk(1, 4'b0100, 2'd2, 1, 0, 0, 8'd0);
    tbl[4]  = mk(1, 4'b1000, 2'd3, 1, 0, 0, 8'd0);
    tbl[5]  = mk(1, 4'b0001, 2'd0, 1, 0, 0, 8'd1); // revolution
    tbl[6]  = mk(1, 4'b0010, 2'd1, 1, 0, 0, 8'd1);
    tbl[7]  = mk(1, 4'b0100, 2'd2, 1, 0, 0, 8'd1);
    tbl[8]  = mk(1, 4'b0100, 2'd2, 1, 0, 0, 8'd1); // hold
    tbl[9]  = mk(1, 4'b0100, 2'd2, 1, 0, 0, 8'd1); // hold
    tbl[10] = mk(0, 4'b0000, 2'd2, 1, 0, 0, 8'd1); // gap
    tbl[11] = mk(0, 4'b1111, 2'd2, 1, 0, 0, 8'd1); // gap, garbage ignored
    tbl[12] = mk(1, 4'b1000, 2'd3, 1, 0, 0, 8'd1);
    tbl[13] = mk(1, 4'b0001, 2'd0, 1, 0, 0, 8'd2);
    tbl[14] = mk(1, 4'b0100, 2'd2, 1, 1, 0, 8'd2); // skip
    tbl[15] = mk(1, 4'b1000, 2'd3, 1, 0, 0, 8'd2);
    tbl[16] = mk(1, 4'b0001, 2'd0, 1, 0, 0, 8'd3);
    tbl[17] = mk(1, 4'b0010, 2'd1, 1, 0, 0, 8'd3);
    tbl[18] = mk(1, 4'b0110, 2'd1, 0, 0, 1, 8'd3); // multi-hot
    tbl[19] = mk(1, 4'b0000, 2'd1, 0, 0, 1, 8'd3); // zero word
    tbl[20] = mk(0, 4'b0001, 2'd1, 0, 0, 0, 8'd3); // gap while searching
    tbl[21] = mk(1, 4'b1000, 2'd3, 1, 0, 0, 8'd3); // relock, no step error
    tbl[22] = mk(1, 4'b0100, 2'd2, 1, 1, 0, 8'd3); // reverse
    tbl[23] = mk(1, 4'b1000, 2'd3, 1, 0, 0, 8'd3);
    tbl[24] = mk(1, 4'b0001, 2'd0, 1, 0, 0, 8'd4);

    reset    = 1'b0;
    in_valid = 1'b1;
    ring_in  = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_index", 32'(index), 32'd0);
    chk("rst_index_valid", 32'(index_valid), 32'd0);
    chk("rst_step_err", 32'(step_err), 32'd0);
    chk("rst_onehot_err", 32'(onehot_err), 32'd0);
    chk("rst_rev_count", 32'(rev_count), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;

    for (int i = 0; i < 25; i++) apply(tbl[i]);

    // 256 revolutions wrap the counter back to its starting value, then one more
    m_idx = 2'd0;
    m_rev = 8'd4;
    rotate(256);
    chk("rev_after_wrap", 32'(rev_count), 32'd4);
    rotate(1);
    chk("rev_before_reset", 32'(rev_count), 32'd5);
`ifdef RING_DECODER_ERRCNT_EN
    chk("err_count_run", 32'(err_count), 32'd5);
`endif

    // asynchronous reset between edges
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_index", 32'(index), 32'd0);
    chk("async_index_valid", 32'(index_valid), 32'd0);
    chk("async_step_err", 32'(step_err), 32'd0);
    chk("async_onehot_err", 32'(onehot_err), 32'd0);
    chk("async_rev_count", 32'(rev_count), 32'd0);
`ifdef RING_DECODER_ERRCNT_EN
    chk("async_err_count", 32'(err_count), 32'd0);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    apply(mk(1, 4'b0010, 2'd1, 1, 0, 0, 8'd0));

`ifdef RING_DECODER_ERRCNT_EN
    apply(mk(1, 4'b0000, 2'd1, 0, 0, 1, 8'd0));
    for (int i = 1; i < 300; i++) begin
      apply(mk(1, 4'b0000, 2'd1, 0, 0, 1, 8'd0));
      if (i == 253) chk("err_count_254", 32'(err_count), 32'd254);
    end
    chk("err_count_sat", 32'(err_count), 32'd255);
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
